// File: rtl/result_burst_packer.sv
// Stages 64-bit result words and emits them as length-prefixed host-write bursts.
// Define RESULT_BURST_CHECKSUM_EN to append an XOR checksum beat to every burst.
module result_burst_packer #(
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 256,
    parameter int LEN_BITS  = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dataInValid,
    input  logic [63:0]         dataIn,
    output logic                dataInReady,
    input  logic                flush,
    output logic                reqValid,
    input  logic                reqReady,
    output logic [LEN_BITS-1:0] reqLength,
    output logic                wordValid,
    input  logic                wordReady,
    output logic [63:0]         wordData,
    output logic                wordLast,
    output logic [31:0]         wordsSent
);
    localparam int PTR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

`ifdef RESULT_BURST_CHECKSUM_EN
    typedef enum logic [1:0] {COLLECT, REQUEST, DRAIN, CHECKSUM} state_t;
`else
    typedef enum logic [1:0] {COLLECT, REQUEST, DRAIN} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [TMR_W-1:0] timer;
    logic             pending;
    logic             run;
    logic [31:0]      words_sent;
    logic [63:0]      stage [BURST_LEN];
    logic             accept, go_request, beat, burst_done, is_last;
`ifdef RESULT_BURST_CHECKSUM_EN
    logic [63:0]      csum;
`endif

    assign accept    = dataInValid && dataInReady;
    assign is_last   = ({1'b0, rd_ptr} == (count - CNT_W'(1)));
    assign wordsSent = words_sent;

    always_comb begin
        state_next  = state;
        dataInReady = 1'b0;
        reqValid    = 1'b0;
        reqLength   = '0;
        wordValid   = 1'b0;
        wordData    = '0;
        wordLast    = 1'b0;
        go_request  = 1'b0;
        beat        = 1'b0;
        burst_done  = 1'b0;
        case (state)
            COLLECT: begin
                // run keeps the input closed for the first cycle out of reset
                dataInReady = run && (count < CNT_W'(BURST_LEN));
                if ((count == CNT_W'(BURST_LEN)) ||
                    ((count != '0) && (pending || (timer == TMR_W'(TIMEOUT))))) begin
                    state_next = REQUEST;
                    go_request = 1'b1;
                end
            end
            REQUEST: begin
                reqValid = 1'b1;
`ifdef RESULT_BURST_CHECKSUM_EN
                reqLength = LEN_BITS'(count) + LEN_BITS'(1);
`else
                reqLength = LEN_BITS'(count);
`endif
                if (reqReady) state_next = DRAIN;
            end
            DRAIN: begin
                wordValid = 1'b1;
                wordData  = stage[rd_ptr];
`ifndef RESULT_BURST_CHECKSUM_EN
                wordLast  = is_last;
`endif
                if (wordReady) begin
                    beat = 1'b1;
                    if (is_last) begin
`ifdef RESULT_BURST_CHECKSUM_EN
                        state_next = CHECKSUM;
`else
                        state_next = COLLECT;
                        burst_done = 1'b1;
`endif
                    end
                end
            end
`ifdef RESULT_BURST_CHECKSUM_EN
            CHECKSUM: begin
                wordValid = 1'b1;
                wordData  = csum;
                wordLast  = 1'b1;
                if (wordReady) begin
                    state_next = COLLECT;
                    burst_done = 1'b1;
                end
            end
`endif
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            count      <= '0;
            rd_ptr     <= '0;
            timer      <= '0;
            pending    <= 1'b0;
            run        <= 1'b0;
            words_sent <= '0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
            if (burst_done)  count <= '0;
            else if (accept) count <= count + CNT_W'(1);
            if (burst_done)  rd_ptr <= '0;
            else if (beat)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (beat) words_sent <= words_sent + 32'd1;
            if ((state != COLLECT) || (count == '0)) timer <= '0;
            else if (timer != TMR_W'(TIMEOUT))       timer <= timer + TMR_W'(1);
            // a flush with nothing staged and nothing arriving has no burst to close
            if (go_request) pending <= 1'b0;
            else if (flush && !((state == COLLECT) && (count == '0) && !accept)) pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) stage[count[PTR_W-1:0]] <= dataIn;
    end

`ifdef RESULT_BURST_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || burst_done) csum <= '0;
        else if (accept)       csum <= csum ^ dataIn;
    end
`endif

endmodule

// File: tb/tb_result_burst_packer.sv
// Randomized and directed bench for result_burst_packer with a scoreboard model of
// accepted words, burst framing, stall stability and the delivered-word count.
module tb_result_burst_packer;
    localparam int BL = 4;
    localparam int TO = 16;
    localparam int LB = 9;
`ifdef RESULT_BURST_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dataInValid = 1'b0;
    logic [63:0]   dataIn = '0;
    logic          dataInReady;
    logic          flush = 1'b0;
    logic          reqValid;
    logic          reqReady = 1'b1;
    logic [LB-1:0] reqLength;
    logic          wordValid;
    logic          wordReady = 1'b1;
    logic [63:0]   wordData;
    logic          wordLast;
    logic [31:0]   wordsSent;

    result_burst_packer #(.BURST_LEN(BL), .TIMEOUT(TO), .LEN_BITS(LB)) dut (
        .clk(clk), .rst(rst), .dataInValid(dataInValid), .dataIn(dataIn),
        .dataInReady(dataInReady), .flush(flush), .reqValid(reqValid),
        .reqReady(reqReady), .reqLength(reqLength), .wordValid(wordValid),
        .wordReady(wordReady), .wordData(wordData), .wordLast(wordLast),
        .wordsSent(wordsSent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard state
    logic [63:0]   acc_q[$];
    logic [LB-1:0] hdr_log[$];
    logic [64:0]   beat_log[$];
    int            hdr_cyc_q[$];
    int            beat_cyc_q[$];
    int            cyc = 0;
    int            last_acc_cyc = 0;
    int            bursts_done = 0;
    int            beats_left = 0;
    int unsigned   exp_sent = 0;
    logic [63:0]   bxor = '0;
    logic          req_hold = 1'b0, word_hold = 1'b0;
    logic [LB-1:0] held_len = '0;
    logic [63:0]   held_data = '0;
    logic          held_last = 1'b0;
    logic [63:0]   exp_words[$];

    always @(negedge clk) begin
        logic [63:0] w;
        cyc++;
        if (rst) begin
            acc_q.delete();
            beats_left = 0;
            exp_sent = 0;
            bxor = '0;
            req_hold = 1'b0;
            word_hold = 1'b0;
        end else begin
            check("words_sent", 64'(wordsSent), 64'(exp_sent));
            if (reqValid || wordValid) check("in_ready_busy", 64'(dataInReady), 64'(0));
            if (req_hold) begin
                check("req_hold_valid", 64'(reqValid), 64'(1));
                check("req_hold_len", 64'(reqLength), 64'(held_len));
            end
            if (word_hold) begin
                check("word_hold_valid", 64'(wordValid), 64'(1));
                check("word_hold_data", wordData, held_data);
                check("word_hold_last", 64'(wordLast), 64'(held_last));
            end
            if (reqValid && !req_hold) hdr_cyc_q.push_back(cyc);
            req_hold  = reqValid && !reqReady;
            held_len  = reqLength;
            word_hold = wordValid && !wordReady;
            held_data = wordData;
            held_last = wordLast;
            if (dataInValid && dataInReady) begin
                acc_q.push_back(dataIn);
                last_acc_cyc = cyc;
            end
            if (reqValid && reqReady) begin
                check("hdr_in_burst", 64'(beats_left), 64'(0));
                check("hdr_len_range", 64'((reqLength >= 1) && (int'(reqLength) <= BL + CS)), 64'(1));
                beats_left = int'(reqLength);
                hdr_log.push_back(reqLength);
                bxor = '0;
            end
            if (wordValid && wordReady) begin
                if (beats_left == 0) begin
                    check("beat_without_hdr", 64'(0), 64'(1));
                end else begin
                    beat_log.push_back({wordLast, wordData});
                    beat_cyc_q.push_back(cyc);
                    if (CS == 1 && beats_left == 1) begin
                        check("csum_data", wordData, bxor);
                        check("csum_last", 64'(wordLast), 64'(1));
                    end else begin
                        if (acc_q.size() == 0) begin
                            check("beat_underrun", 64'(0), 64'(1));
                        end else begin
                            w = acc_q.pop_front();
                            check("beat_data", wordData, w);
                            bxor ^= w;
                        end
                        check("beat_last", 64'(wordLast), 64'(CS == 0 && beats_left == 1));
                        exp_sent++;
                    end
                    beats_left--;
                    if (beats_left == 0) bursts_done++;
                end
            end
        end
    end

    task automatic push(input logic [63:0] w);
        int n = 0;
        dataInValid = 1'b1;
        dataIn = w;
        @(negedge clk);
        while (!dataInReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!dataInReady) check("push_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        dataInValid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_bursts(input int target);
        int n = 0;
        while (bursts_done < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_burst", 64'(bursts_done >= target), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        hdr_log.delete();
        beat_log.delete();
        hdr_cyc_q.delete();
        beat_cyc_q.delete();
    endtask

    task automatic expect_burst(input string tag);
        int n;
        logic [63:0] x;
        n = exp_words.size();
        x = '0;
        check({tag, "_nhdr"}, 64'(hdr_log.size()), 64'(1));
        check({tag, "_len"}, (hdr_log.size() > 0) ? 64'(hdr_log[0]) : 64'(0), 64'(n + CS));
        check({tag, "_nbeats"}, 64'(beat_log.size()), 64'(n + CS));
        for (int i = 0; i < n && i < beat_log.size(); i++) begin
            check({tag, "_data"}, beat_log[i][63:0], exp_words[i]);
            check({tag, "_last"}, 64'(beat_log[i][64]), 64'(CS == 0 && i == n - 1));
            x ^= exp_words[i];
        end
        if (CS == 1 && beat_log.size() > n) begin
            check({tag, "_csum"}, beat_log[n][63:0], x);
            check({tag, "_csum_last"}, 64'(beat_log[n][64]), 64'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int b0;
        int n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(dataInReady), 64'(0));
        check("rst_req_valid", 64'(reqValid), 64'(0));
        check("rst_req_len", 64'(reqLength), 64'(0));
        check("rst_word_valid", 64'(wordValid), 64'(0));
        check("rst_word_data", wordData, 64'(0));
        check("rst_word_last", 64'(wordLast), 64'(0));
        check("rst_words_sent", 64'(wordsSent), 64'(0));

        // Full burst at full rate
        clear_logs();
        b0 = bursts_done;
        exp_words = '{64'h1, 64'h2, 64'h3, 64'h4};
        foreach (exp_words[i]) push(exp_words[i]);
        d = last_acc_cyc;
        wait_bursts(b0 + 1);
        expect_burst("t1");
        if (hdr_cyc_q.size() > 0) check("t1_latency_min", 64'(hdr_cyc_q[0] - d >= 2), 64'(1));
        if (beat_cyc_q.size() >= 4) check("t1_back_to_back", 64'(beat_cyc_q[3] - beat_cyc_q[0]), 64'(3));
        check("t1_sent", 64'(wordsSent), 64'(4));
        check("t1_ready_back", 64'(dataInReady), 64'(1));

        // Single word forced out by the inactivity timer
        clear_logs();
        b0 = bursts_done;
        exp_words = '{64'hAB};
        push(64'hAB);
        d = last_acc_cyc;
        wait_bursts(b0 + 1);
        expect_burst("t2");
        if (hdr_cyc_q.size() > 0) begin
            check("t2_timeout_late", 64'(hdr_cyc_q[0] - d <= TO + 2), 64'(1));
            check("t2_timeout_early", 64'(hdr_cyc_q[0] - d >= TO), 64'(1));
        end

        // Explicit flush of a partial burst, then a flush with nothing staged
        clear_logs();
        b0 = bursts_done;
        exp_words = '{64'h11, 64'h22};
        push(64'h11);
        push(64'h22);
        pulse_flush();
        wait_bursts(b0 + 1);
        expect_burst("t3");
        clear_logs();
        pulse_flush();
        repeat (30) @(posedge clk);
        #1 check("t3_empty_flush_no_hdr", 64'(hdr_log.size()), 64'(0));
        b0 = bursts_done;
        exp_words = '{64'h33};
        push(64'h33);
        d = last_acc_cyc;
        wait_bursts(b0 + 1);
        expect_burst("t3b");
        if (hdr_cyc_q.size() > 0) check("t3_no_stale_pending", 64'(hdr_cyc_q[0] - d >= TO), 64'(1));
        check("t3_sent", 64'(wordsSent), 64'(8));

        // Header and beat stalls
        clear_logs();
        b0 = bursts_done;
        reqReady = 1'b0;
        exp_words = '{64'h40, 64'h41, 64'h42, 64'h43};
        foreach (exp_words[i]) push(exp_words[i]);
        n = 0;
        while (!reqValid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1 reqReady = 1'b1;
        n = 0;
        while (bursts_done < b0 + 1 && n < 60) begin
            @(posedge clk); #1;
            wordReady = !wordReady;
            n++;
        end
        wordReady = 1'b1;
        wait_bursts(b0 + 1);
        expect_burst("t4");
        check("t4_sent", 64'(wordsSent), 64'(12));

        // Reset in the middle of a drain
        clear_logs();
        foreach (exp_words[i]) exp_words[i] = 64'hA0 + 64'(i);
        foreach (exp_words[i]) push(exp_words[i]);
        n = 0;
        while (beat_log.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_req_valid", 64'(reqValid), 64'(0));
        check("t5_word_valid", 64'(wordValid), 64'(0));
        check("t5_word_data", wordData, 64'(0));
        check("t5_word_last", 64'(wordLast), 64'(0));
        check("t5_in_ready", 64'(dataInReady), 64'(0));
        check("t5_sent", 64'(wordsSent), 64'(0));
        clear_logs();
        b0 = bursts_done;
        exp_words = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
        foreach (exp_words[i]) push(exp_words[i]);
        wait_bursts(b0 + 1);
        expect_burst("t5");
        check("t5_sent_after", 64'(wordsSent), 64'(4));

        // One-hot words so the checksum beat is easy to read
        clear_logs();
        b0 = bursts_done;
        exp_words = '{64'h1, 64'h2, 64'h4, 64'h8};
        foreach (exp_words[i]) push(exp_words[i]);
        wait_bursts(b0 + 1);
        expect_burst("t6");
        check("t6_sent", 64'(wordsSent), 64'(8));

        // Random traffic, flushes and back-pressure
        for (int i = 0; i < 600; i++) begin
            dataInValid = ($urandom_range(0, 3) != 0);
            dataIn = {$urandom, $urandom};
            flush = ($urandom_range(0, 24) == 0);
            reqReady = ($urandom_range(0, 3) != 0);
            wordReady = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        dataInValid = 1'b0;
        reqReady = 1'b1;
        wordReady = 1'b1;
        pulse_flush();
        n = 0;
        while ((acc_q.size() != 0 || beats_left != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("rand_drained", 64'(acc_q.size() + beats_left), 64'(0));
        check("rand_sent", 64'(wordsSent), 64'(exp_sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/result_burst_packer.md
Name: result_burst_packer

Overview:
- Sits directly downstream of the pipeline output buffer.
- Pulls 64-bit result words from the buffer through a valid/ready handshake and stages them in a local store.
- Emits them to the host-write interface as length-prefixed bursts: a request beat carrying the length, then the data words with a last marker.
- Partial bursts are flushed on an inactivity timeout or on an explicit end-of-job flush.

Parameters:
- BURST_LEN, 16, maximum data words per burst; power of two, 2..256.
- TIMEOUT, 256, cycles after the first staged word before a partial burst is forced out; must be ≥ 1.
- LEN_BITS, 9, width of reqLength; must satisfy 2^LEN_BITS > BURST_LEN+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dataInValid  in  1  buffer has a word (buffer's !empty)
- dataIn  in  64  word from buffer
- dataInReady  out  1  word accepted this cycle when dataInValid && dataInReady; drives buffer read enable
- flush  in  1  single-cycle pulse: emit any staged words now
- reqValid  out  1  burst header valid
- reqReady  in  1  host accepts header
- reqLength  out  LEN_BITS  number of word beats that follow
- wordValid  out  1  burst data beat valid
- wordReady  in  1  host accepts beat
- wordData  out  64  beat payload
- wordLast  out  1  final beat of burst
- wordsSent  out  32  running count of data words delivered (excludes checksum beats)

Behaviour:
- Reset (synchronous, active-high):
  - state=COLLECT; stage count, read pointer, timer, pending flag and wordsSent = 0.
  - All outputs 0; staged contents discarded.
  - Reset mid-burst abandons the burst with no further beats; the host side is also reset.
- States: COLLECT, REQUEST, DRAIN (plus CHECKSUM with the optional feature).
- COLLECT:
  - dataInReady = (count < BURST_LEN); each handshake writes stage[count], count++.
  - Timer clears while count==0; otherwise increments once per cycle from the cycle after the first word is accepted.
  - Go to REQUEST in the cycle after any of: count reaches BURST_LEN; count>0 and timer reaches TIMEOUT; pending flag set and count>0.
  - A word accepted in the same cycle as a timeout or flush is included in the burst.
- flush:
  - Sets the pending flag.
  - Pending clears when REQUEST is entered, or immediately if count==0 and no word is accepted that cycle (flush on empty is a no-op).
  - flush during REQUEST/DRAIN stays pending and applies to the next burst.
- REQUEST:
  - reqValid=1; reqLength = count (count+1 with the optional feature), held stable until reqReady.
  - Go to DRAIN on the reqValid && reqReady cycle; dataInReady=0.
- DRAIN:
  - wordValid=1; wordData = stage[rdPtr]; wordLast = (rdPtr == count-1) and the optional feature is off.
  - wordData/wordLast held stable while wordValid && !wordReady.
  - On handshake: rdPtr++ and wordsSent++; wordsSent wraps mod 2^32.
  - After the last beat: COLLECT with count=0, rdPtr=0, timer=0 (or CHECKSUM with the optional feature).
  - dataInReady=0 throughout; the upstream buffer absorbs the stall.
- Latency:
  - First header no earlier than 2 cycles after the BURST_LEN-th word is accepted.
  - Back-to-back beats at 1 per cycle when wordReady is held high.
- Stage store:
  - Registered; read data must be presented combinationally from rdPtr, so no bubble between beats.
  - May use a RAM only with a prefetch register that preserves the 1-beat/cycle rule.

Optional Feature:
- Macro: RESULT_BURST_CHECKSUM_EN.
- Defined:
  - A 64-bit XOR of all data words in the burst is accumulated as words are accepted in COLLECT.
  - After the last data beat, state CHECKSUM emits one extra beat: wordData = checksum, wordLast=1.
  - reqLength = count+1; data beats never assert wordLast.
  - Checksum clears on return to COLLECT and on reset.
- Not defined: no CHECKSUM state, no accumulator logic; reqLength = count.

Test Plan:
- BURST_LEN=4, wordReady=reqReady=1; push 1,2,3,4 on consecutive cycles -> one header reqLength=4, beats 1,2,3,4 with wordLast only on 4; wordsSent=4; dataInReady=0 from REQUEST until after beat 4.
- TIMEOUT=16; push single word 0xAB, then nothing -> header reqLength=1 appears within 18 cycles of acceptance; beat 0xAB with wordLast=1.
- Push 2 words, pulse flush; also pulse flush with count=0 -> burst of length 2; the empty flush produces no header.
- Hold reqReady=0 for 5 cycles, then toggle wordReady 1,0,1,0 -> reqLength/wordData/wordLast stable during stalls; no lost or duplicated beats; order preserved.
- Assert rst during DRAIN after 1 beat of 4 -> next cycle all outputs 0, wordsSent=0; new words form a fresh burst starting at stage[0].
- With RESULT_BURST_CHECKSUM_EN, push 0x1,0x2,0x4,0x8 -> reqLength=5, fifth beat 0xF with wordLast=1, wordsSent=4.
